alu_seq: RTL and testbench

Multi-cycle, handshaked ALU that accepts one operation request at a time and returns a registered result with a one-cycle completion pulse. It is the responder side of the ALU request protocol: a driver (processor control unit or bench) presents operands and an opcode with START, then waits for DONE. Add, subtract, shift, logical and compare finish in one cycle. Multiply uses an iterative shift-add datapath that takes DATA_WIDTH cycles. The block sits between the control unit and the register-file write-back path.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// ALU request/response bus: the requester drives operands, opcode and the
// start strobe; the ALU returns the registered result with status flags.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
);
  logic                  start;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [OPRN_WIDTH-1:0] oprn;
  logic [DATA_WIDTH-1:0] out;
  logic                  zero;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, op1, op2, oprn,
    input  out, zero, busy, done, err
  );

  modport slave (
    input  start, op1, op2, oprn,
    output out, zero, busy, done, err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU. Single-cycle ops go IDLE -> CALC -> IDLE;
// multiply runs an iterative shift-add loop for DATA_WIDTH cycles in MUL.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;

  // Request latched at acceptance; later bus changes do not reach these.
  logic [DATA_WIDTH-1:0] op1_p0;
  logic [DATA_WIDTH-1:0] op2_p0;
  logic [OPRN_WIDTH-1:0] oprn_p0;

  // Shift-add multiplier working registers.
  logic [DATA_WIDTH-1:0] acc_p1;
  logic [DATA_WIDTH-1:0] mcand_p1;
  logic [DATA_WIDTH-1:0] mplier_p1;

  logic                  accept;
  logic                  last_iter;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH:0]   calc;

  // Single-cycle result; MSB is the unsupported-opcode flag. Multiply never
  // reaches CALC, so its entry only keeps it out of the error default.
  function automatic logic [DATA_WIDTH:0] alu_eval(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [OPRN_WIDTH-1:0] op
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  e;
    logic                  big;
    r   = '0;
    e   = 1'b0;
    big = (b >= DATA_WIDTH'(DATA_WIDTH));
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = '0;
      OP_SRL:  r = big ? '0 : (a >> b);
      OP_SLL:  r = big ? '0 : (a << b);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  assign accept    = (state == S_IDLE) && bus.start;
  assign last_iter = (count == LAST_CNT);
  assign acc_next  = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;
  assign calc      = alu_eval(op1_p0, op2_p0, oprn_p0);
  assign bus.busy  = (state != S_IDLE);

  // Control FSM and registered result/flags; reset discards any request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      bus.out  <= '0;
      bus.zero <= 1'b1;
      bus.err  <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            count <= '0;
            state <= (bus.oprn == OP_MUL) ? S_MUL : S_CALC;
          end
        end
        S_CALC: begin
          bus.out  <= calc[DATA_WIDTH-1:0];
          bus.zero <= (calc[DATA_WIDTH-1:0] == '0);
          bus.err  <= calc[DATA_WIDTH];
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        S_MUL: begin
          count <= count + 1'b1;
          if (last_iter) begin
            bus.out  <= acc_next;
            bus.zero <= (acc_next == '0);
            bus.err  <= 1'b0;
            bus.done <= 1'b1;
            count    <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on acceptance, then one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_p0    <= bus.op1;
      op2_p0    <= bus.op2;
      oprn_p0   <= bus.oprn;
      acc_p1    <= '0;
      mcand_p1  <= bus.op1;
      mplier_p1 <= bus.op2;
    end else if (state == S_MUL) begin
      acc_p1    <= acc_next;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, single-cycle ops, multiply latency,
// handshake rules, error opcode and reset during a multiply.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();

  alu_seq #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift / logic / compare vectors: opcode, op1, op2, expected OUT.
  logic [5:0]  lv_op [0:11] = '{6'h04, 6'h05, 6'h05, 6'h04, 6'h04, 6'h06,
                                6'h07, 6'h08, 6'h09, 6'h09, 6'h09, 6'h09};
  logic [31:0] lv_a  [0:11] = '{32'd18, 32'd5, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3,
                                32'd3, 32'd3, 32'd3, 32'd17, 32'hFFFF_FFFD, 32'hFFFF_FFF9};
  logic [31:0] lv_b  [0:11] = '{32'd3, 32'd3, 32'd32, 32'd31, 32'hFFFF_FFFF, 32'd5,
                                32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFD};
  logic [31:0] lv_e  [0:11] = '{32'd2, 32'd40, 32'd0, 32'd1, 32'd0, 32'd1,
                                32'd7, 32'hFFFF_FFF8, 32'd1, 32'd0, 32'd0, 32'd1};

  // Multiply vectors: op1, op2, expected OUT.
  logic [31:0] mv_a [0:2] = '{32'd3, 32'h0001_0000, 32'd0};
  logic [31:0] mv_b [0:2] = '{32'd5, 32'h0001_0000, 32'd5};
  logic [31:0] mv_e [0:2] = '{32'd15, 32'd0, 32'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.oprn  = op;
    bus.op1   = a;
    bus.op2   = b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    step();
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL rst_out got=%h exp=%h", bus.out, 32'd0); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", bus.zero); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    rst = 1'b1;
  endtask

  task automatic test_add_sub();
    drive(6'h01, 32'd15, 32'd3);
    step();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL add_busy_e0 got=%b exp=1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_e0 got=%b exp=0", bus.done); end
    step();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL add_done_e1 got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_busy_e1 got=%b exp=0", bus.busy); end
    total++; if (bus.out !== 32'd18) begin bad++; $display("FAIL add_out got=%h exp=%h", bus.out, 32'd18); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", bus.zero); end
    step();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_e2 got=%b exp=0", bus.done); end
    total++; if (bus.out !== 32'd18) begin bad++; $display("FAIL add_hold got=%h exp=%h", bus.out, 32'd18); end
    drive(6'h02, 32'd8, 32'd8);
    step();
    bus.start = 1'b0;
    step();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL sub_done got=%b exp=1", bus.done); end
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL sub_out got=%h exp=%h", bus.out, 32'd0); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b exp=1", bus.zero); end
    step();
  endtask

  task automatic test_mul();
    int lat;
    int busy_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(6'h03, mv_a[i], mv_b[i]);
      step();
      bus.start = 1'b0;
      lat = 0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 40) begin
        step();
        lat++;
        if (!bus.done && bus.busy) busy_cnt++;
      end
      total++; if (lat !== 32) begin bad++; $display("FAIL mul%0d_latency got=%0d exp=32", i, lat); end
      total++; if (busy_cnt !== 32) begin bad++; $display("FAIL mul%0d_busy_cycles got=%0d exp=32", i, busy_cnt); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mul%0d_busy_at_done got=%b exp=0", i, bus.busy); end
      total++; if (bus.out !== mv_e[i]) begin bad++; $display("FAIL mul%0d_out got=%h exp=%h", i, bus.out, mv_e[i]); end
      total++; if (bus.zero !== (mv_e[i] == 32'd0)) begin bad++; $display("FAIL mul%0d_zero got=%b exp=%b", i, bus.zero, (mv_e[i] == 32'd0)); end
      step();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mul%0d_done_pulse got=%b exp=0", i, bus.done); end
    end
  endtask

  task automatic test_logic();
    for (int i = 0; i < 12; i++) begin
      drive(lv_op[i], lv_a[i], lv_b[i]);
      step();
      bus.start = 1'b0;
      step();
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL logic%0d_done got=%b exp=1", i, bus.done); end
      total++; if (bus.out !== lv_e[i]) begin bad++; $display("FAIL logic%0d_out op=%h got=%h exp=%h", i, lv_op[i], bus.out, lv_e[i]); end
      total++; if (bus.zero !== (lv_e[i] == 32'd0)) begin bad++; $display("FAIL logic%0d_zero got=%b exp=%b", i, bus.zero, (lv_e[i] == 32'd0)); end
      step();
    end
  endtask

  task automatic test_handshake();
    int lat;
    // Known OUT before the multiply so holding can be checked mid-flight.
    drive(6'h01, 32'd2, 32'd2);
    step();
    bus.start = 1'b0;
    step();
    step();
    drive(6'h03, 32'd7, 32'd9);
    step();
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin step(); lat++; end
    drive(6'h01, 32'd1, 32'd1);
    step();
    lat++;
    bus.start = 1'b0;
    bus.op1 = 32'd100;
    step();
    lat++;
    total++; if (bus.out !== 32'd4) begin bad++; $display("FAIL hs_out_hold got=%h exp=%h", bus.out, 32'd4); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hs_busy_mid got=%b exp=1", bus.busy); end
    while (!bus.done && lat < 40) begin step(); lat++; end
    total++; if (lat !== 32) begin bad++; $display("FAIL hs_latency got=%0d exp=32", lat); end
    total++; if (bus.out !== 32'd63) begin bad++; $display("FAIL hs_out got=%h exp=%h", bus.out, 32'd63); end
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hs_no_queue_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hs_no_queue_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_back_to_back();
    drive(6'h01, 32'd10, 32'd20);
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      total++; if (bus.done !== k[0]) begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", k, bus.done, k[0]); end
      total++; if (bus.busy !== !k[0]) begin bad++; $display("FAIL b2b_busy%0d got=%b exp=%b", k, bus.busy, !k[0]); end
      if (k[0]) begin
        total++; if (bus.out !== 32'd30) begin bad++; $display("FAIL b2b_out%0d got=%h exp=%h", k, bus.out, 32'd30); end
      end
    end
    bus.start = 1'b0;
    step();
    step();
  endtask

  task automatic test_error();
    drive(6'h0F, 32'd5, 32'd5);
    step();
    bus.start = 1'b0;
    step();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL err_done got=%b exp=1", bus.done); end
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL err_out got=%h exp=%h", bus.out, 32'd0); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL err_zero got=%b exp=1", bus.zero); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", bus.err); end
    step();
    step();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", bus.err); end
    drive(6'h01, 32'd2, 32'd3);
    step();
    bus.start = 1'b0;
    step();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.err); end
    total++; if (bus.out !== 32'd5) begin bad++; $display("FAIL err_next_out got=%h exp=%h", bus.out, 32'd5); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int seen_done;
    drive(6'h03, 32'd7, 32'd9);
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    rst = 1'b0;
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmul_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmul_done got=%b exp=0", bus.done); end
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL rmul_out got=%h exp=%h", bus.out, 32'd0); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rmul_zero got=%b exp=1", bus.zero); end
    rst = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.done || bus.busy) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL rmul_discard got=%0d exp=0", seen_done); end
    drive(6'h01, 32'd1, 32'd1);
    step();
    bus.start = 1'b0;
    step();
    total++; if (bus.out !== 32'd2) begin bad++; $display("FAIL rmul_recover got=%h exp=%h", bus.out, 32'd2); end
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.oprn = '0;
    test_reset();
    test_add_sub();
    test_mul();
    test_logic();
    test_handshake();
    test_back_to_back();
    test_error();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
